// File: rtl/seg_msg_scroller_pkg.sv
// seg_msg_pkg: shared definitions for the 7-segment message scroller.
//  - MSG_LEN and the 5-bit character codes used in the message ROM
//  - display mode encoding
//  - char_to_seg : character code -> active-low segment pattern (bit0=a .. bit6=g)
//  - state_to_msg: traffic FSM state -> 8-character message, element 0 = leftmost
//  - state_has_msg: 1 when the state code has a defined message
package seg_msg_pkg;

    localparam int MSG_LEN = 8;

    typedef enum logic [4:0] {
        CH_0     = 5'd0,
        CH_1     = 5'd1,
        CH_2     = 5'd2,
        CH_3     = 5'd3,
        CH_4     = 5'd4,
        CH_5     = 5'd5,
        CH_6     = 5'd6,
        CH_7     = 5'd7,
        CH_8     = 5'd8,
        CH_9     = 5'd9,
        CH_A     = 5'd10,
        CH_B     = 5'd11,  // lower-case b
        CH_C     = 5'd12,
        CH_D     = 5'd13,  // lower-case d
        CH_E     = 5'd14,
        CH_F     = 5'd15,
        CH_G     = 5'd16,
        CH_H     = 5'd17,
        CH_I     = 5'd18,
        CH_L     = 5'd19,
        CH_N     = 5'd20,  // lower-case n
        CH_O     = 5'd21,
        CH_P     = 5'd22,
        CH_R     = 5'd23,  // lower-case r
        CH_S     = 5'd24,
        CH_T     = 5'd25,  // lower-case t
        CH_U     = 5'd26,
        CH_DASH  = 5'd27,
        CH_BLANK = 5'd28
    } char_t;

    typedef enum logic [1:0] {
        MODE_STATIC     = 2'b00,
        MODE_SCROLL     = 2'b01,
        MODE_BLINK      = 2'b10,
        MODE_STATIC_ALT = 2'b11
    } mode_t;

    // One 5-bit character code per slot; slot 0 is the leftmost character.
    typedef logic [MSG_LEN-1:0][4:0] msg_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] char_to_seg(input char_t c);
        logic [6:0] seg;
        case (c)
            CH_0:     seg = 7'b1000000;
            CH_1:     seg = 7'b1111001;
            CH_2:     seg = 7'b0100100;
            CH_3:     seg = 7'b0110000;
            CH_4:     seg = 7'b0011001;
            CH_5:     seg = 7'b0010010;
            CH_6:     seg = 7'b0000010;
            CH_7:     seg = 7'b1111000;
            CH_8:     seg = 7'b0000000;
            CH_9:     seg = 7'b0010000;
            CH_A:     seg = 7'b0001000;
            CH_B:     seg = 7'b0000011;
            CH_C:     seg = 7'b1000110;
            CH_D:     seg = 7'b0100001;
            CH_E:     seg = 7'b0000110;
            CH_F:     seg = 7'b0001110;
            CH_G:     seg = 7'b1000010;
            CH_H:     seg = 7'b0001001;
            CH_I:     seg = 7'b1111001;
            CH_L:     seg = 7'b1000111;
            CH_N:     seg = 7'b0101011;
            CH_O:     seg = 7'b1000000;
            CH_P:     seg = 7'b0001100;
            CH_R:     seg = 7'b0101111;
            CH_S:     seg = 7'b0010010;
            CH_T:     seg = 7'b0000111;
            CH_U:     seg = 7'b1000001;
            CH_DASH:  seg = 7'b0111111;
            default:  seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic state_has_msg(input logic [2:0] s);
        return (s == 3'b000) || (s == 3'b010) || (s == 3'b011);
    endfunction

    function automatic msg_t state_to_msg(input logic [2:0] s);
        msg_t m;
        for (int i = 0; i < MSG_LEN; i++) begin
            m[i] = CH_BLANK;
        end
        case (s)
            3'b000: begin
                m[0] = CH_G;
                m[1] = CH_O;
            end
            3'b010: begin
                m[0] = CH_S;
                m[1] = CH_T;
                m[2] = CH_O;
                m[3] = CH_P;
            end
            3'b011: begin
                m[0] = CH_C;
                m[1] = CH_A;
                m[2] = CH_U;
                m[3] = CH_T;
                m[4] = CH_I;
                m[5] = CH_O;
                m[6] = CH_N;
            end
            default: begin
                for (int i = 0; i < MSG_LEN; i++) begin
                    m[i] = CH_DASH;
                end
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/seg_msg_scroller_if.sv
// seg_msg_scroller_if: bundle between the traffic FSM side and the scroller.
//  state (3)          traffic FSM state code
//  mode  (2)          00 static, 01 scroll, 10 blink, 11 static
//  HEX   (7*N_DIGITS) active-low segments, digit k at [7k+6:7k], k=0 rightmost
//  err   (1)          state has no defined message
//  wrap  (1)          one-cycle pulse when the scroll offset wraps to 0
interface seg_msg_scroller_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic [2:0]            state;
    logic [1:0]            mode;
    logic [7*N_DIGITS-1:0] HEX;
    logic                  err;
    logic                  wrap;

    modport master (output state, output mode, input HEX, input err, input wrap);
    modport slave  (input state, input mode, output HEX, output err, output wrap);
endinterface

// File: rtl/seg_msg_scroller_tick_gen.sv
// seg_tick_gen: terminal-count divider producing the scroll/blink step.
//  clk   in   clock
//  rst   in   asynchronous active-high reset, counter -> 0
//  clr   in   synchronous clear, restarts a full period
//  tick  out  high for the one cycle the counter sits at TERMINAL
module seg_tick_gen #(
    parameter int unsigned TERMINAL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(TERMINAL + 1);

    logic [CW-1:0] count_reg;

    assign tick = (count_reg == CW'(TERMINAL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr || tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end
endmodule

// File: rtl/seg_msg_scroller.sv
// seg_msg_scroller: N-digit 7-segment message display for the traffic light
// controller. The FSM state selects an 8-character message which is shown
// static, scrolling right-to-left, or blinking, stepped by an internal tick.
//  CLOCK_50  in   system clock
//  KEY       in   asynchronous active-high reset
//  bus       slave modport: state/mode in, HEX/err/wrap out
module seg_msg_scroller
    import seg_msg_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TICK_HZ  = 1,
    parameter int unsigned N_DIGITS = 4
) (
    input  logic               CLOCK_50,
    input  logic               KEY,
    seg_msg_scroller_if.slave  bus
);
    localparam int unsigned TICK_TC = CLK_HZ / TICK_HZ - 1;
    localparam int          OW      = $clog2(MSG_LEN);

    logic [2:0]            state_q;
    logic [1:0]            mode_q;
    logic                  change;
    logic                  tick;
    logic [OW-1:0]         offset_reg, offset_next;
    logic                  phase_reg, phase_next;
    logic                  wrap_reg, wrap_next;
    logic [7*N_DIGITS-1:0] hex_reg, hex_next;
    logic                  err_reg;
    msg_t                  msg;

    // Compares the raw inputs against their registered copies, so the
    // change is seen on the same edge that loads state_q/mode_q.
    assign change = (bus.state != state_q) || (bus.mode != mode_q);

    seg_tick_gen #(
        .TERMINAL(TICK_TC)
    ) u_tick (
        .clk  (CLOCK_50),
        .rst  (KEY),
        .clr  (change),
        .tick (tick)
    );

    // Offset/phase/wrap next-state. A change restarts the message and wins
    // over a coincident tick.
    always_comb begin
        offset_next = offset_reg;
        phase_next  = phase_reg;
        wrap_next   = 1'b0;
        if (change) begin
            offset_next = '0;
            phase_next  = 1'b0;
        end else begin
            if (mode_q == MODE_SCROLL) begin
                if (tick) begin
                    if (offset_reg == OW'(MSG_LEN - 1)) begin
                        offset_next = '0;
                        wrap_next   = 1'b1;
                    end else begin
                        offset_next = offset_reg + OW'(1);
                    end
                end
            end else begin
                offset_next = '0;
            end
            if (mode_q == MODE_BLINK) begin
                if (tick) begin
                    phase_next = ~phase_reg;
                end
            end else begin
                phase_next = 1'b0;
            end
        end
    end

    assign msg = state_to_msg(state_q);

    // Digit gi shows character (offset + N_DIGITS-1-gi) mod MSG_LEN; the
    // modulo is the natural overflow of the OW-bit sum since MSG_LEN is 2**OW.
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
        localparam logic [OW-1:0] SKEW = OW'(N_DIGITS - 1 - gi);
        logic [OW-1:0] idx;
        assign idx = offset_reg + SKEW;
        assign hex_next[7*gi +: 7] = phase_reg ? SEG_BLANK : char_to_seg(char_t'(msg[idx]));
    end

    always_ff @(posedge CLOCK_50 or posedge KEY) begin
        if (KEY) begin
            state_q    <= '0;
            mode_q     <= '0;
            offset_reg <= '0;
            phase_reg  <= 1'b0;
            wrap_reg   <= 1'b0;
            hex_reg    <= '1;
            err_reg    <= 1'b0;
        end else begin
            state_q    <= bus.state;
            mode_q     <= bus.mode;
            offset_reg <= offset_next;
            phase_reg  <= phase_next;
            wrap_reg   <= wrap_next;
            hex_reg    <= hex_next;
            err_reg    <= !state_has_msg(state_q);
        end
    end

    assign bus.HEX  = hex_reg;
    assign bus.err  = err_reg;
    assign bus.wrap = wrap_reg;
endmodule

// File: tb/tb_seg_msg_scroller.sv
// Bench for seg_msg_scroller: 4-digit and 8-digit instances, CLK_HZ=8, TICK_HZ=1.
module tb_seg_msg_scroller;

    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SU = 7'b1000001;
    localparam logic [6:0] ST = 7'b0000111;
    localparam logic [6:0] SI = 7'b1111001;
    localparam logic [6:0] SO = 7'b1000000;
    localparam logic [6:0] SN = 7'b0101011;
    localparam logic [6:0] SG = 7'b1000010;
    localparam logic [6:0] SS = 7'b0010010;
    localparam logic [6:0] SP = 7'b0001100;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    localparam int T_GO     = 0;
    localparam int T_H0A    = 1;
    localparam int T_H0B    = 2;
    localparam int T_H1A    = 3;
    localparam int T_H1B    = 4;
    localparam int T_H2     = 5;
    localparam int T_WRAP   = 6;
    localparam int T_TIE    = 7;
    localparam int T_RST    = 8;
    localparam int T_WIDE   = 9;
    localparam int T_PRERST = 10;

    typedef struct packed {
        int          due;
        bit          wide;
        logic [55:0] hex;
        logic        err;
        int          tag;
    } exp_t;

    typedef struct packed {
        logic [2:0]  st;
        logic [1:0]  md;
        logic [27:0] h0;
        logic [27:0] h1;
        logic [27:0] h2;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic KEY = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   wrap_count = 0;
    int   wrap_last = -1;
    exp_t sb[$];
    vec_t vecs[8];
    string tag_name[11];
    logic [6:0] caut[8];

    seg_msg_scroller_if #(.N_DIGITS(4)) bus4();
    seg_msg_scroller_if #(.N_DIGITS(8)) bus8();

    seg_msg_scroller #(.CLK_HZ(8), .TICK_HZ(1), .N_DIGITS(4)) dut4 (
        .CLOCK_50 (clk),
        .KEY      (KEY),
        .bus      (bus4)
    );

    seg_msg_scroller #(.CLK_HZ(8), .TICK_HZ(1), .N_DIGITS(8)) dut8 (
        .CLOCK_50 (clk),
        .KEY      (KEY),
        .bus      (bus8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [27:0] d4(input logic [6:0] a, input logic [6:0] b,
                                       input logic [6:0] c, input logic [6:0] d);
        return {a, b, c, d};
    endfunction

    task automatic expect4(input int due, input logic [27:0] h, input logic e, input int tag);
        exp_t x;
        x.due  = due;
        x.wide = 1'b0;
        x.hex  = {28'd0, h};
        x.err  = e;
        x.tag  = tag;
        sb.push_back(x);
    endtask

    task automatic expect8(input int due, input logic [55:0] h, input int tag);
        exp_t x;
        x.due  = due;
        x.wide = 1'b1;
        x.hex  = h;
        x.err  = 1'b0;
        x.tag  = tag;
        sb.push_back(x);
    endtask

    task automatic check_now(input string name, input logic [55:0] got, input logic [55:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: pops every expectation that falls due on this cycle.
    always @(negedge clk) begin
        exp_t        x;
        logic [55:0] got_hex;
        logic        got_err;
        if (bus4.wrap === 1'b1) begin
            wrap_count++;
            wrap_last = cyc;
        end
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            x = sb.pop_front();
            if (x.wide) begin
                got_hex = bus8.HEX;
                got_err = bus8.err;
            end else begin
                got_hex = {28'd0, bus4.HEX};
                got_err = bus4.err;
            end
            n_checks++;
            if (x.due != cyc || got_hex !== x.hex || got_err !== x.err) begin
                n_errors++;
                $display("FAIL %s due=%0d at=%0d: got hex=%h err=%b, want hex=%h err=%b",
                         tag_name[x.tag], x.due, cyc, got_hex, got_err, x.hex, x.err);
            end
        end
    end

    initial begin
        int p;
        int q;
        int w0;
        logic [55:0] h8;

        tag_name = '{"go_stable", "vec_h0a", "vec_h0b", "vec_h1a", "vec_h1b", "vec_h2",
                     "wrap_seq", "tick_tie", "rst_restart", "wide_scroll", "err_pre_rst"};
        caut = '{SC, SA, SU, ST, SI, SO, SN, SB};

        vecs[0] = '{3'b010, 2'b01, d4(SS, ST, SO, SP), d4(ST, SO, SP, SB), d4(SO, SP, SB, SB), 1'b0};
        vecs[1] = '{3'b011, 2'b10, d4(SC, SA, SU, ST), d4(SB, SB, SB, SB), d4(SC, SA, SU, ST), 1'b0};
        vecs[2] = '{3'b000, 2'b00, d4(SG, SO, SB, SB), d4(SG, SO, SB, SB), d4(SG, SO, SB, SB), 1'b0};
        vecs[3] = '{3'b111, 2'b00, d4(SD, SD, SD, SD), d4(SD, SD, SD, SD), d4(SD, SD, SD, SD), 1'b1};
        vecs[4] = '{3'b000, 2'b11, d4(SG, SO, SB, SB), d4(SG, SO, SB, SB), d4(SG, SO, SB, SB), 1'b0};
        vecs[5] = '{3'b011, 2'b01, d4(SC, SA, SU, ST), d4(SA, SU, ST, SI), d4(SU, ST, SI, SO), 1'b0};
        vecs[6] = '{3'b100, 2'b10, d4(SD, SD, SD, SD), d4(SB, SB, SB, SB), d4(SD, SD, SD, SD), 1'b1};
        vecs[7] = '{3'b010, 2'b00, d4(SS, ST, SO, SP), d4(SS, ST, SO, SP), d4(SS, ST, SO, SP), 1'b0};

        bus4.state = 3'b000;
        bus4.mode  = 2'b00;
        bus8.state = 3'b000;
        bus8.mode  = 2'b00;
        KEY = 1'b1;

        // Reset state
        @(negedge clk);
        check_now("reset_hex", {28'd0, bus4.HEX}, 56'h0000000FFFFFFF);
        check_now("reset_err", {55'd0, bus4.err}, 56'd0);
        check_now("reset_wrap", {55'd0, bus4.wrap}, 56'd0);

        // Release with GO/static: stable for 40 cycles from +2
        wait_cycles(2);
        KEY = 1'b0;
        p = cyc;
        $display("txn release: state=000 mode=00");
        for (int i = 2; i < 42; i++) begin
            expect4(p + i, d4(SG, SO, SB, SB), 1'b0, T_GO);
        end
        wait_cycles(42);

        // Table vectors: +2 and +9 first view, +10 and +17 after one tick, +18 after two
        for (int i = 0; i < 8; i++) begin
            bus4.state = vecs[i].st;
            bus4.mode  = vecs[i].md;
            p = cyc;
            $display("txn vec %0d: state=%b mode=%b", i, vecs[i].st, vecs[i].md);
            expect4(p + 2,  vecs[i].h0, vecs[i].err, T_H0A);
            expect4(p + 9,  vecs[i].h0, vecs[i].err, T_H0B);
            expect4(p + 10, vecs[i].h1, vecs[i].err, T_H1A);
            expect4(p + 17, vecs[i].h1, vecs[i].err, T_H1B);
            expect4(p + 18, vecs[i].h2, vecs[i].err, T_H2);
            wait_cycles(20);
        end

        // Full scroll lap: offset 7 view, wrap pulse once, back to offset 0
        w0 = wrap_count;
        bus4.state = 3'b010;
        bus4.mode  = 2'b01;
        p = cyc;
        $display("txn wrap lap: state=010 mode=01");
        expect4(p + 2,  d4(SS, ST, SO, SP), 1'b0, T_WRAP);
        expect4(p + 58, d4(SB, SS, ST, SO), 1'b0, T_WRAP);
        expect4(p + 66, d4(SS, ST, SO, SP), 1'b0, T_WRAP);
        wait_cycles(70);
        check_now("wrap_count", 56'(wrap_count - w0), 56'd1);
        check_now("wrap_cycle", 56'(wrap_last), 56'(p + 65));

        // Change on the same edge as a tick
        w0 = wrap_count;
        bus4.state = 3'b000;
        bus4.mode  = 2'b01;
        p = cyc;
        $display("txn tick tie: state=000 mode=01 then state=011 on tick");
        expect4(p + 2, d4(SG, SO, SB, SB), 1'b0, T_TIE);
        wait_cycles(8);
        bus4.state = 3'b011;
        q = cyc;
        expect4(q + 2,  d4(SC, SA, SU, ST), 1'b0, T_TIE);
        expect4(q + 9,  d4(SC, SA, SU, ST), 1'b0, T_TIE);
        expect4(q + 10, d4(SA, SU, ST, SI), 1'b0, T_TIE);
        wait_cycles(12);
        check_now("tie_no_wrap", 56'(wrap_count - w0), 56'd0);

        // Reset in the middle of scrolling an error message
        bus4.state = 3'b111;
        bus4.mode  = 2'b01;
        p = cyc;
        $display("txn reset mid-scroll: state=111 mode=01");
        expect4(p + 2,  d4(SD, SD, SD, SD), 1'b1, T_PRERST);
        expect4(p + 10, d4(SD, SD, SD, SD), 1'b1, T_PRERST);
        wait_cycles(12);
        #2;
        KEY = 1'b1;
        #1;
        check_now("midrst_hex", {28'd0, bus4.HEX}, 56'h0000000FFFFFFF);
        check_now("midrst_err", {55'd0, bus4.err}, 56'd0);
        check_now("midrst_wrap", {55'd0, bus4.wrap}, 56'd0);
        bus4.state = 3'b010;
        bus4.mode  = 2'b01;
        wait_cycles(2);
        KEY = 1'b0;
        p = cyc;
        expect4(p + 2,  d4(SS, ST, SO, SP), 1'b0, T_RST);
        expect4(p + 9,  d4(SS, ST, SO, SP), 1'b0, T_RST);
        expect4(p + 10, d4(ST, SO, SP, SB), 1'b0, T_RST);
        wait_cycles(12);

        // 8-digit instance scrolling CAUtIOn through more than one lap
        bus8.state = 3'b011;
        bus8.mode  = 2'b01;
        p = cyc;
        $display("txn wide scroll: state=011 mode=01 N_DIGITS=8");
        for (int k = 0; k < 10; k++) begin
            for (int d = 0; d < 8; d++) begin
                h8[7*d +: 7] = caut[(k + 7 - d) % 8];
            end
            expect8(p + 2 + 8 * k, h8, T_WIDE);
        end
        wait_cycles(80);

        check_now("sb_drained", 56'(sb.size()), 56'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
